// File: rtl/route_compute_arbiter.sv
// route_compute_arbiter
//   Shares one head-flit route-compute decoder among NUM_REQ router input ports.
//   A round-robin arbiter picks a port with a pending head flit and presents the
//   flit to the decoder until it answers or times out. The route result then goes
//   back to the granted port as a one-cycle ack.
//
// Ports
//   clk             clock, all logic on posedge
//   rst             synchronous active-low reset
//   req_valid       per-port head flit pending, held until acked
//   req_flit        per-port head flit, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack         one-hot single-cycle pulse, route result valid for that port
//   route_out       route result, meaningful only while req_ack != 0
//   route_err       with req_ack: decoder timed out and route_out is 0
//   HeadFlit        flit to the decoder, stable throughout a decode
//   decodeHeadFlit  decode request level to the decoder
//   headFlitDecoded decoder done, RequestMessage valid this cycle
//   RequestMessage  decoder route result
//   busy            arbiter is not idle
module route_compute_arbiter #(
  parameter int unsigned NUM_REQ       = 5,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_flit,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [REQUEST_WIDTH-1:0]      route_out,
  output logic                          route_err,
  output logic [DATA_WIDTH-1:0]         HeadFlit,
  output logic                          decodeHeadFlit,
  input  logic                          headFlitDecoded,
  input  logic [REQUEST_WIDTH-1:0]      RequestMessage,
  output logic                          busy
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  // Sized to hold TIMEOUT-1 even when TIMEOUT is 1.
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StDecode, StResp} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]          grant_q, grant_d;
  logic [TimerW-1:0]        timer_q, timer_d;
  logic [DATA_WIDTH-1:0]    head_flit_q, head_flit_d;
  logic                     decode_q, decode_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic [REQUEST_WIDTH-1:0] route_q, route_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  logic [DATA_WIDTH-1:0]    flit_arr [NUM_REQ];
  logic                     pick_found;
  logic [IdxW-1:0]          pick_idx;
  logic [IdxW-1:0]          cand;
  logic [IdxW-1:0]          next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_flit
    assign flit_arr[g] = req_flit[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan starting at rr_ptr; first requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign next_ptr = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    head_flit_d = head_flit_q;
    decode_d    = decode_q;
    ack_d       = '0;
    route_d     = '0;
    err_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          head_flit_d = flit_arr[pick_idx];
          decode_d    = 1'b1;
          timer_d     = '0;
          state_d     = StDecode;
        end
      end
      StDecode: begin
        timer_d = timer_q + TimerW'(1);
        // A decode completing on the timeout cycle still counts as a success.
        if (headFlitDecoded) begin
          decode_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          route_d        = RequestMessage;
          state_d        = StResp;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          decode_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = StResp;
        end else if (!req_valid[grant_q]) begin
          // Port withdrew: drop the decode silently and move past it.
          decode_d = 1'b0;
          rr_ptr_d = next_ptr;
          state_d  = StIdle;
        end
      end
      StResp: begin
        rr_ptr_d = next_ptr;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      timer_q     <= '0;
      head_flit_q <= '0;
      decode_q    <= 1'b0;
      ack_q       <= '0;
      route_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      head_flit_q <= head_flit_d;
      decode_q    <= decode_d;
      ack_q       <= ack_d;
      route_q     <= route_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack        = ack_q;
  assign route_out      = route_q;
  assign route_err      = err_q;
  assign HeadFlit       = head_flit_q;
  assign decodeHeadFlit = decode_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_route_compute_arbiter.sv
// tb_route_compute_arbiter
//   Directed bench for route_compute_arbiter with a small decoder model whose
//   route result is (HeadFlit[2:0] + 1) mod 8 and whose response can be
//   immediate, delayed by three cycles, or absent.
module tb_route_compute_arbiter;

  logic        clk;
  logic        rst;
  logic [4:0]  req_valid;
  logic [39:0] req_flit;
  logic [4:0]  req_ack;
  logic [2:0]  route_out;
  logic        route_err;
  logic [7:0]  HeadFlit;
  logic        decodeHeadFlit;
  logic        headFlitDecoded;
  logic [2:0]  RequestMessage;
  logic        busy;

  logic [7:0]  flit [5];
  int          dec_mode;  // 0 immediate, 1 never, 2 after three cycles
  int          dcnt;
  int          n_checks;
  int          n_err;

  route_compute_arbiter #(
    .NUM_REQ      (5),
    .DATA_WIDTH   (8),
    .REQUEST_WIDTH(3),
    .TIMEOUT      (15)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_flit       (req_flit),
    .req_ack        (req_ack),
    .route_out      (route_out),
    .route_err      (route_err),
    .HeadFlit       (HeadFlit),
    .decodeHeadFlit (decodeHeadFlit),
    .headFlitDecoded(headFlitDecoded),
    .RequestMessage (RequestMessage),
    .busy           (busy)
  );

  assign req_flit        = {flit[4], flit[3], flit[2], flit[1], flit[0]};
  assign RequestMessage  = HeadFlit[2:0] + 3'd1;
  assign headFlitDecoded = decodeHeadFlit && (dec_mode == 0 || (dec_mode == 2 && dcnt >= 3));

  always @(posedge clk) begin
    if (!decodeHeadFlit) dcnt <= 0;
    else                 dcnt <= dcnt + 1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] valid;
    logic [4:0] exp_ack;
    logic [2:0] exp_route;
    logic       exp_err;
    logic       exp_dec;
    logic [7:0] exp_flit;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(logic [4:0] v, logic [4:0] a, logic [2:0] r, logic e, logic d,
                              logic [7:0] f, logic b);
    vec_t t;
    t.valid = v; t.exp_ack = a; t.exp_route = r; t.exp_err = e;
    t.exp_dec = d; t.exp_flit = f; t.exp_busy = b;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int           order [6];
    logic [2:0]   rt [5];
    logic [7:0]   fl [5];
    int           n;

    n_checks = 0;
    n_err    = 0;
    dec_mode = 0;
    dcnt     = 0;
    flit[0] = 8'h03; flit[1] = 8'h14; flit[2] = 8'h09; flit[3] = 8'h2E; flit[4] = 8'h35;
    fl[0] = 8'h03; fl[1] = 8'h14; fl[2] = 8'h09; fl[3] = 8'h2E; fl[4] = 8'h35;
    // Hand-computed decoder answers for the flits above.
    rt[0] = 3'd4; rt[1] = 3'd5; rt[2] = 3'd2; rt[3] = 3'd7; rt[4] = 3'd6;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 4; order[5] = 0;

    // All ports requesting: DECODE, RESP, IDLE per grant.
    for (int g = 0; g < 6; g++) begin
      vecs[3*g]     = mk(5'b11111, 5'b0, 3'd0, 1'b0, 1'b1, fl[order[g]], 1'b1);
      vecs[3*g + 1] = mk(5'b11111, 5'(1 << order[g]), rt[order[g]], 1'b0, 1'b0, 8'h00, 1'b1);
      vecs[3*g + 2] = mk(5'b11111, 5'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    // Lone request on port 2.
    vecs[18] = mk(5'b00100, 5'b00000, 3'd0, 1'b0, 1'b1, 8'h09, 1'b1);
    vecs[19] = mk(5'b00100, 5'b00100, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1);
    vecs[20] = mk(5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset held with every port requesting.
    rst       = 1'b0;
    req_valid = 5'b11111;
    step();
    step();
    chk("reset ack", 32'(req_ack), 0);
    chk("reset route", 32'(route_out), 0);
    chk("reset err", 32'(route_err), 0);
    chk("reset headflit", 32'(HeadFlit), 0);
    chk("reset decode", 32'(decodeHeadFlit), 0);
    chk("reset busy", 32'(busy), 0);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      req_valid = vecs[i].valid;
      step();
      chk($sformatf("row%0d ack", i), 32'(req_ack), 32'(vecs[i].exp_ack));
      chk($sformatf("row%0d decode", i), 32'(decodeHeadFlit), 32'(vecs[i].exp_dec));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_dec)
        chk($sformatf("row%0d headflit", i), 32'(HeadFlit), 32'(vecs[i].exp_flit));
      if (vecs[i].exp_ack != 5'b0) begin
        chk($sformatf("row%0d route", i), 32'(route_out), 32'(vecs[i].exp_route));
        chk($sformatf("row%0d err", i), 32'(route_err), 32'(vecs[i].exp_err));
      end
    end

    // Decoder never answers: timeout after 15 DECODE cycles.
    dec_mode  = 1;
    req_valid = 5'b01000;
    step();
    n = 0;
    while (decodeHeadFlit && n < 40) begin
      n++;
      step();
    end
    chk("timeout decode cycles", 32'(n), 15);
    chk("timeout ack", 32'(req_ack), 32'(5'b01000));
    chk("timeout err", 32'(route_err), 1);
    chk("timeout route", 32'(route_out), 0);
    req_valid = 5'b00000;
    step();
    chk("timeout idle ack", 32'(req_ack), 0);
    // rr_ptr must now sit at 4, so port 0 beats port 3.
    dec_mode  = 0;
    req_valid = 5'b01001;
    step();
    chk("timeout rr headflit", 32'(HeadFlit), 32'(8'h03));
    step();
    chk("timeout rr ack", 32'(req_ack), 32'(5'b00001));
    req_valid = 5'b00000;
    step();

    // Port 1 withdraws while the decoder is slow.
    dec_mode  = 2;
    req_valid = 5'b00110;
    step();
    chk("withdraw headflit", 32'(HeadFlit), 32'(8'h14));
    step();
    req_valid = 5'b00100;
    step();
    chk("withdraw decode", 32'(decodeHeadFlit), 0);
    chk("withdraw ack", 32'(req_ack), 0);
    chk("withdraw busy", 32'(busy), 0);
    step();
    chk("withdraw regrant headflit", 32'(HeadFlit), 32'(8'h09));
    n = 0;
    while (req_ack == 5'b0 && n < 20) begin
      n++;
      step();
    end
    chk("withdraw regrant ack", 32'(req_ack), 32'(5'b00100));
    chk("withdraw regrant route", 32'(route_out), 2);
    chk("withdraw regrant err", 32'(route_err), 0);
    req_valid = 5'b00000;
    step();

    // Reset in the middle of a decode.
    dec_mode  = 1;
    req_valid = 5'b00001;
    step();
    chk("midreset decode before", 32'(decodeHeadFlit), 1);
    rst = 1'b0;
    step();
    chk("midreset decode", 32'(decodeHeadFlit), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset ack", 32'(req_ack), 0);
    rst      = 1'b1;
    dec_mode = 0;
    step();
    chk("postreset headflit", 32'(HeadFlit), 32'(8'h03));
    step();
    chk("postreset ack", 32'(req_ack), 32'(5'b00001));
    chk("postreset route", 32'(route_out), 4);
    req_valid = 5'b00000;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
